stereo_out_scheduler: RTL
=========================

// Module: stereo_out_scheduler
// PURPOSE
//  Paces stereo output of fm_radio at a fixed audio sample rate. Pops the left/right audio FIFOs
//  (first-word fall-through) in lockstep, once per sample tick. Emits the pair as one interleaved
//  valid/ready stream, L then R. Counts underruns (FIFO not ready at tick) and slips (tick missed
//  because the sink is stalled). Sits between the fm_radio gain stages' output FIFOs and the audio sink.
// PARAMETERS
//  DATA_SIZE  32  audio sample width (matches globals.sv)
//  PERIOD     8   clock cycles per stereo sample tick; must be >= 3
//  UCNT_W     16  width of underrun_count and slip_count (saturating)
// PORTS
//  clock              in   1          system clock, rising edge
//  reset              in   1          asynchronous, active-low (0 = in reset)
//  enable             in   1          run request
//  left_audio_dout    in   DATA_SIZE  left FIFO head word, valid while left_audio_empty=0
//  left_audio_empty   in   1          left FIFO empty
//  left_audio_rd_en   out  1          left FIFO pop
//  right_audio_dout   in   DATA_SIZE  right FIFO head word
//  right_audio_empty  in   1          right FIFO empty
//  right_audio_rd_en  out  1          right FIFO pop
//  out_data           out  DATA_SIZE  interleaved sample
//  out_is_right       out  1          0 = left sample, 1 = right sample
//  out_valid          out  1          out_data valid
//  out_ready          in   1          sink accepts when out_valid & out_ready
//  underrun_count     out  UCNT_W     ticks with either FIFO empty
//  slip_count         out  UCNT_W     ticks occurring outside WAIT_TICK
//  busy               out  1          state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, tick_cnt=0, L/R regs=0, all outputs 0, both counters 0.
//   Reset mid-operation discards the latched pair; out_valid drops immediately; no pop occurs.
//  Tick counter: cleared to 0 on IDLE->WAIT_TICK. Increments every cycle while state != IDLE.
//   tick=1 when tick_cnt==PERIOD-1; counter then wraps to 0.
//  FSM states IDLE, WAIT_TICK, SEND_L, SEND_R:
//   IDLE:      enable=1 -> WAIT_TICK.
//   WAIT_TICK: enable=0 -> IDLE (takes priority over tick).
//              tick & both empty=0 -> drive both rd_en=1 combinationally this cycle,
//                latch both dout into L/R regs -> SEND_L.
//              tick & either empty=1 -> no rd_en; underrun_count+1 (sat); stay.
//   SEND_L:    out_valid=1, out_data=L reg, out_is_right=0; out_ready -> SEND_R.
//   SEND_R:    out_valid=1, out_data=R reg, out_is_right=1; out_ready -> WAIT_TICK if enable,
//              else IDLE.
//  enable is ignored in SEND_L/SEND_R; an in-flight pair always completes.
//  A tick in SEND_L/SEND_R is dropped and slip_count+1 (sat); no deferred fetch.
//  Pop rules: left/right rd_en always identical. Each rd_en is a 1-cycle pulse, only on a fetch cycle.
//   Never asserted while either empty=1.
//  Latency: fetch on tick cycle t -> out_valid at t+1. With out_ready=1: L accepted t+1,
//   R accepted t+2, back in WAIT_TICK at t+3. Next tick at t+PERIOD.
//  out_data and out_is_right are held stable while out_valid=1 and out_ready=0.
//  Counters saturate at 2^UCNT_W-1; cleared only by reset.
// TESTING
//  1. 4 pairs preloaded (L=0x11..0x44, R=0xA1..0xA4), ready=1, enable=1 -> stream 11,A1,22,A2,..
//     Pairs start 8 cycles apart; four single-cycle rd_en pulses; both counters 0.
//  2. Right FIFO empty, left holds 1 word -> no rd_en; underrun_count +1 per tick.
//     Write right 0xB0 -> next tick pops both; left word then 0xB0 emitted.
//  3. out_ready=0 for 16 cycles starting at first SEND_L cycle -> out_data holds L value.
//     slip_count=2; stream resumes R then next pair.
//  4. enable=0 during SEND_L -> L and R still emitted; then IDLE, busy=0; no rd_en afterwards.
//  5. reset=0 asserted asynchronously mid-SEND_R -> out_valid=0 same cycle; no extra pop.
//     After release: busy=0, counters 0.
//  6. UCNT_W=4, FIFOs empty, 20 ticks -> underrun_count=15 (saturated).

Source files
------------

// File: rtl/stereo_out_scheduler.sv
// Paces stereo playback: pops the L/R FIFOs together once per sample tick
// and streams the pair out as interleaved L,R beats on a valid/ready port.
module stereo_out_scheduler #(
    parameter int DATA_SIZE = 32,
    parameter int PERIOD    = 8,
    parameter int UCNT_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] left_audio_dout,
    input  logic                 left_audio_empty,
    output logic                 left_audio_rd_en,
    input  logic [DATA_SIZE-1:0] right_audio_dout,
    input  logic                 right_audio_empty,
    output logic                 right_audio_rd_en,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_is_right,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [UCNT_W-1:0]    underrun_count,
    output logic [UCNT_W-1:0]    slip_count,
    output logic                 busy
);

    localparam int TW = $clog2(PERIOD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND_L,
        S_SEND_R
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_tick_cnt;
    logic [DATA_SIZE-1:0]  r_left;
    logic [DATA_SIZE-1:0]  r_right;
    logic [UCNT_W-1:0]     r_underrun;
    logic [UCNT_W-1:0]     r_slip;

    logic w_tick;
    logic w_fetch;
    logic w_sending;

    assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == TW'(PERIOD - 1));
    assign w_fetch   = (r_state == S_WAIT) && enable && w_tick
                       && !left_audio_empty && !right_audio_empty;
    assign w_sending = (r_state == S_SEND_L) || (r_state == S_SEND_R);

    // Pops are combinational so the FWFT head is latched on the same edge.
    assign left_audio_rd_en  = w_fetch;
    assign right_audio_rd_en = w_fetch;

    assign out_valid      = w_sending;
    assign out_is_right   = (r_state == S_SEND_R);
    assign out_data       = (r_state == S_SEND_R) ? r_right : r_left;
    assign underrun_count = r_underrun;
    assign slip_count     = r_slip;
    assign busy           = (r_state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_underrun <= '0;
            r_slip     <= '0;
        end else begin
            if (r_state == S_IDLE || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            // A tick landing while a pair is still draining is lost.
            if (w_sending && w_tick && r_slip != '1) begin
                r_slip <= r_slip + 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (enable) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_fetch) begin
                        r_left  <= left_audio_dout;
                        r_right <= right_audio_dout;
                        r_state <= S_SEND_L;
                    end else if (w_tick && r_underrun != '1) begin
                        r_underrun <= r_underrun + 1'b1;
                    end
                end
                S_SEND_L: begin
                    if (out_ready) r_state <= S_SEND_R;
                end
                S_SEND_R: begin
                    if (out_ready) r_state <= enable ? S_WAIT : S_IDLE;
                end
            endcase
        end
    end

endmodule
